trap_sequencer: RTL and testbench

Machine-mode trap and return sequencer for the multicycle RV32I core. It sits between the main control FSM and the PC mux/register and owns mtvec, mepc, mcause and mstatus.MIE/MPIE. At instruction boundaries it decides whether to take an external interrupt or ecall, or to execute an mret. It then drives the PC source select and PC write-enable for the redirect cycles while stalling the main FSM.

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_sequencer_if.sv | 36 +++
 rtl/trap_csr_file.sv | 98 +++++++++
 rtl/trap_sequencer.sv | 139 +++++++++++++
 tb/tb_trap_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned PCSEL_W = 3;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        RUN,
        TRAP_SAVE,
        TRAP_JUMP,
        MRET_JUMP
    } trap_state_e;

    typedef enum logic [PCSEL_W-1:0] {
        PC_PLUS4  = 3'b000,
        PC_JALR   = 3'b001,
        PC_BRANCH = 3'b010,
        PC_JAL    = 3'b011,
        PC_MTVEC  = 3'b100,
        PC_MEPC   = 3'b101
    } pc_sel_e;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    // PC-holding CSRs are always word aligned.
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Core-side bus of the trap sequencer: decode/PC inputs, CSR port, redirect outputs.
interface trap_sequencer_if;
    import trap_pkg::*;

    logic                irq;
    logic                instr_done;
    logic                is_ecall;
    logic                is_mret;
    logic [XLEN-1:0]     next_pc;
    logic [PCSEL_W-1:0]  pcSource_in;
    logic                pcWrite_in;
    logic                csr_we;
    logic [CSR_AW-1:0]   csr_addr;
    logic [XLEN-1:0]     csr_wdata;

    logic [PCSEL_W-1:0]  pcSource;
    logic                pcWrite;
    logic                stall;
    logic                int_taken;
    logic [XLEN-1:0]     mtvec;
    logic [XLEN-1:0]     mepc;
    logic [XLEN-1:0]     csr_rdata;

    modport master (
        output irq, instr_done, is_ecall, is_mret, next_pc, pcSource_in, pcWrite_in,
               csr_we, csr_addr, csr_wdata,
        input  pcSource, pcWrite, stall, int_taken, mtvec, mepc, csr_rdata
    );

    modport slave (
        input  irq, instr_done, is_ecall, is_mret, next_pc, pcSource_in, pcWrite_in,
               csr_we, csr_addr, csr_wdata,
        output pcSource, pcWrite, stall, int_taken, mtvec, mepc, csr_rdata
    );

endinterface

// File: rtl/trap_csr_file.sv
// mtvec/mepc/mcause/mstatus storage; trap and mret updates override software writes.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               csr_we,
    input  logic [CSR_AW-1:0]  csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    input  logic               epc_we,
    input  logic [XLEN-1:0]    epc_val,
    input  logic               trap_we,
    input  logic [XLEN-1:0]    trap_cause,
    input  logic               mret_we,
    output logic [XLEN-1:0]    mtvec,
    output logic [XLEN-1:0]    mepc,
    output logic               mie,
    output logic [XLEN-1:0]    csr_rdata
);

    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtvec_q  <= RESET_VEC;
            mepc_q   <= '0;
            mcause_q <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

    // Software write first; hardware sequencer updates later in the block win.
    always_comb begin
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;

        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata[MSTATUS_MIE_BIT];
                    mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:  mtvec_d  = align4(csr_wdata);
                CSR_MEPC:   mepc_d   = align4(csr_wdata);
                CSR_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (epc_we) begin
            mepc_d = align4(epc_val);
        end
        if (trap_we) begin
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
        if (mret_we) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = mie_q;
                csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MTVEC:  csr_rdata = mtvec_q;
            CSR_MEPC:   csr_rdata = mepc_q;
            CSR_MCAUSE: csr_rdata = mcause_q;
            default: ;
        endcase
    end

    assign mtvec = mtvec_q;
    assign mepc  = mepc_q;
    assign mie   = mie_q;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: redirects the PC and stalls the main FSM.
// Define IRQ_SYNC_EN to pass irq through a 2-flop synchronizer.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter logic [31:0] IRQ_CAUSE   = 32'h8000_000B,
    parameter logic [31:0] ECALL_CAUSE = 32'h0000_000B
) (
    input  logic             clk,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);

    logic irq_s;

`ifdef IRQ_SYNC_EN
    logic irq_meta_q, irq_meta_d;
    logic irq_sync_q, irq_sync_d;

    always_comb begin
        irq_meta_d = bus.irq;
        irq_sync_d = irq_meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= irq_meta_d;
            irq_sync_q <= irq_sync_d;
        end
    end

    assign irq_s = irq_sync_q;
`else
    assign irq_s = bus.irq;
`endif

    trap_state_e         state_q, state_d;
    logic [XLEN-1:0]     cause_q, cause_d;
    logic [PCSEL_W-1:0]  pc_source;
    logic                pc_write;
    logic                stall;
    logic                int_taken;
    logic                epc_we;
    logic                trap_we;
    logic                mret_we;
    logic                mie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pc_source = bus.pcSource_in;
        pc_write  = bus.pcWrite_in;
        stall     = 1'b0;
        int_taken = 1'b0;
        epc_we    = 1'b0;
        trap_we   = 1'b0;
        mret_we   = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.instr_done) begin
                    if (bus.is_mret) begin
                        state_d = MRET_JUMP;
                    end else if (bus.is_ecall) begin
                        state_d  = TRAP_SAVE;
                        cause_d  = ECALL_CAUSE;
                        pc_write = 1'b0;
                        epc_we   = 1'b1;
                    end else if (irq_s && mie) begin
                        state_d   = TRAP_SAVE;
                        cause_d   = IRQ_CAUSE;
                        pc_write  = 1'b0;
                        epc_we    = 1'b1;
                        int_taken = 1'b1;
                    end
                end
            end
            TRAP_SAVE: begin
                stall    = 1'b1;
                pc_write = 1'b0;
                trap_we  = 1'b1;
                state_d  = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                stall     = 1'b1;
                pc_source = PC_MTVEC;
                pc_write  = 1'b1;
                state_d   = RUN;
            end
            MRET_JUMP: begin
                stall     = 1'b1;
                pc_source = PC_MEPC;
                pc_write  = 1'b1;
                mret_we   = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    trap_csr_file #(
        .RESET_VEC (RESET_VEC)
    ) u_csr (
        .clk        (clk),
        .reset      (reset),
        .csr_we     (bus.csr_we),
        .csr_addr   (bus.csr_addr),
        .csr_wdata  (bus.csr_wdata),
        .epc_we     (epc_we),
        .epc_val    (bus.next_pc),
        .trap_we    (trap_we),
        .trap_cause (cause_q),
        .mret_we    (mret_we),
        .mtvec      (bus.mtvec),
        .mepc       (bus.mepc),
        .mie        (mie),
        .csr_rdata  (bus.csr_rdata)
    );

    assign bus.pcSource  = pc_source;
    assign bus.pcWrite   = pc_write;
    assign bus.stall     = stall;
    assign bus.int_taken = int_taken;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes expectations, a negedge monitor checks them.
module tb_trap_sequencer;
    import trap_pkg::*;

    localparam logic [31:0] RV   = 32'h0000_0800;
    localparam logic [31:0] IRQC = 32'h8000_000B;
    localparam logic [31:0] ECC  = 32'h0000_000B;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    trap_sequencer_if bus();

    trap_sequencer #(
        .RESET_VEC   (RV),
        .IRQ_CAUSE   (IRQC),
        .ECALL_CAUSE (ECC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // kind: 0 no redirect, 1 trap, 2 mret
    typedef struct {
        int          kind;
        bit          itk;
        logic [2:0]  pcs;
        bit          pcw;
        logic [31:0] target;
        logic [31:0] mcause;
        logic [31:0] mepc;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] val;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    bit   rd_chk = 1'b0;
    bit   mon_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Architectural reference state
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    bit          m_mie, m_mpie;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endfunction

    function automatic void model_reset();
        m_mtvec  = RV;
        m_mepc   = '0;
        m_mcause = '0;
        m_mie    = 1'b0;
        m_mpie   = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] w);
        case (a)
            12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
            12'h305: m_mtvec  = w & 32'hFFFF_FFFC;
            12'h341: m_mepc   = w & 32'hFFFF_FFFC;
            12'h342: m_mcause = w;
            default: ;
        endcase
    endfunction

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 12'h300;
            1: return 12'h305;
            2: return 12'h341;
            3: return 12'h342;
            default: return 12'h340;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.instr_done  = 1'b0;
        bus.is_ecall    = 1'b0;
        bus.is_mret     = 1'b0;
        bus.csr_we      = 1'b0;
        bus.pcSource_in = 3'($urandom_range(0, 3));
        bus.pcWrite_in  = 1'($urandom_range(0, 1));
        bus.next_pc     = $urandom;
        bus.csr_wdata   = $urandom;
        rd_chk          = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] w);
        quiet();
        bus.csr_we    = 1'b1;
        bus.csr_addr  = a;
        bus.csr_wdata = w;
        model_write(a, w);
        cyc();
    endtask

    task automatic csr_rd(input logic [11:0] a);
        rd_t r;
        quiet();
        bus.csr_addr = a;
        r.addr = a;
        r.val  = model_read(a);
        rd_q.push_back(r);
        rd_chk = 1'b1;
        cyc();
    endtask

    task automatic drive_idle(input bit allow_wr);
        int act;
        act = $urandom_range(0, 3);
        if (act == 1 || (act == 2 && !allow_wr)) csr_rd(pick_addr());
        else if (act == 2) csr_wr(pick_addr(), $urandom);
        else begin
            quiet();
            bus.csr_addr = pick_addr();
            cyc();
        end
    endtask

    task automatic do_instr(input bit ec, input bit mr, input bit iq, input logic [31:0] npc,
                            input bit wr_epc, input logic [31:0] wd, input int nidle, input bit allow_wr);
        exp_t e;
        int nstall;
        bus.irq = iq;
        repeat (nidle) drive_idle(allow_wr);
        quiet();
        bus.instr_done = 1'b1;
        bus.is_ecall   = ec;
        bus.is_mret    = mr;
        bus.next_pc    = npc;
        bus.csr_we     = wr_epc;
        bus.csr_addr   = CSR_MEPC;
        bus.csr_wdata  = wd;
        e.pcs = bus.pcSource_in;
        e.pcw = bus.pcWrite_in;
        e.itk = 1'b0;
        if (mr) begin
            if (wr_epc) m_mepc = wd & 32'hFFFF_FFFC;
            e.kind = 2;
            e.target = m_mepc;
            m_mie  = m_mpie;
            m_mpie = 1'b1;
            nstall = 1;
        end else if (ec || (iq && m_mie)) begin
            e.kind   = 1;
            e.itk    = !ec;
            m_mepc   = npc & 32'hFFFF_FFFC;
            m_mcause = ec ? ECC : IRQC;
            m_mpie   = m_mie;
            m_mie    = 1'b0;
            e.target = m_mtvec;
            nstall   = 2;
        end else begin
            if (wr_epc) m_mepc = wd & 32'hFFFF_FFFC;
            e.kind   = 0;
            e.target = '0;
            nstall   = 0;
        end
        e.mcause = m_mcause;
        e.mepc   = m_mepc;
        exp_q.push_back(e);
        cyc();
        repeat (nstall) begin
            quiet();
            bus.csr_addr = CSR_MCAUSE;
            cyc();
        end
    endtask

    // Monitor: consumes expectations as the DUT presents decisions and redirects.
    initial begin
        int   phase;
        exp_t cur;
        rd_t  r;
        phase = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            case (phase)
                0: begin
                    if (rd_chk) begin
                        if (rd_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL rd_q: read check with no expectation queued");
                        end else begin
                            r = rd_q.pop_front();
                            chk($sformatf("csr_rdata[%h]", r.addr), bus.csr_rdata, r.val);
                        end
                    end
                    if (bus.instr_done) begin
                        if (exp_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL exp_q: decision cycle with no expectation queued");
                        end else begin
                            cur = exp_q.pop_front();
                            chk("dec_stall", 32'(bus.stall), 32'(0));
                            chk("dec_pcSource", 32'(bus.pcSource), 32'(cur.pcs));
                            chk("dec_pcWrite", 32'(bus.pcWrite), (cur.kind == 1) ? 32'(0) : 32'(cur.pcw));
                            chk("dec_int_taken", 32'(bus.int_taken), 32'(cur.itk));
                            phase = (cur.kind == 1) ? 1 : (cur.kind == 2) ? 3 : 0;
                        end
                    end else begin
                        chk("run_stall", 32'(bus.stall), 32'(0));
                        chk("run_pcSource", 32'(bus.pcSource), 32'(bus.pcSource_in));
                        chk("run_pcWrite", 32'(bus.pcWrite), 32'(bus.pcWrite_in));
                        chk("run_int_taken", 32'(bus.int_taken), 32'(0));
                    end
                end
                1: begin
                    chk("save_stall", 32'(bus.stall), 32'(1));
                    chk("save_pcWrite", 32'(bus.pcWrite), 32'(0));
                    chk("save_int_taken", 32'(bus.int_taken), 32'(0));
                    chk("save_mepc", bus.mepc, cur.mepc);
                    phase = 2;
                end
                2: begin
                    chk("tjump_stall", 32'(bus.stall), 32'(1));
                    chk("tjump_pcSource", 32'(bus.pcSource), 32'(3'b100));
                    chk("tjump_pcWrite", 32'(bus.pcWrite), 32'(1));
                    chk("tjump_mtvec", bus.mtvec, cur.target);
                    chk("tjump_mcause", bus.csr_rdata, cur.mcause);
                    chk("tjump_mepc", bus.mepc, cur.mepc);
                    chk("tjump_int_taken", 32'(bus.int_taken), 32'(0));
                    phase = 0;
                end
                default: begin
                    chk("mjump_stall", 32'(bus.stall), 32'(1));
                    chk("mjump_pcSource", 32'(bus.pcSource), 32'(3'b101));
                    chk("mjump_pcWrite", 32'(bus.pcWrite), 32'(1));
                    chk("mjump_mepc", bus.mepc, cur.target);
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.irq         = 1'b0;
        bus.csr_addr    = CSR_MSTATUS;
        quiet();
        bus.pcSource_in = 3'b011;
        bus.pcWrite_in  = 1'b1;
        model_reset();
        repeat (3) cyc();

        // Reset state
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'(0));
        chk("rst_int_taken", 32'(bus.int_taken), 32'(0));
        chk("rst_mtvec", bus.mtvec, RV);
        chk("rst_mepc", bus.mepc, 32'h0);
        chk("rst_mstatus", bus.csr_rdata, 32'h0);
        chk("rst_pcSource", 32'(bus.pcSource), 32'(3'b011));
        chk("rst_pcWrite", 32'(bus.pcWrite), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset asserted mid-TRAP_SAVE drops the trap
        csr_wr(CSR_MTVEC, 32'h0000_0200);
        csr_wr(CSR_MSTATUS, 32'h8);
        quiet();
        bus.instr_done = 1'b1;
        bus.is_ecall   = 1'b1;
        bus.next_pc    = 32'h0000_0040;
        bus.pcWrite_in = 1'b1;
        @(negedge clk);
        chk("rst_dec_pcWrite", 32'(bus.pcWrite), 32'(0));
        @(posedge clk); #1;
        quiet();
        bus.csr_addr = CSR_MSTATUS;
        @(negedge clk);
        chk("rst_save_stall", 32'(bus.stall), 32'(1));
        chk("rst_save_mepc", bus.mepc, 32'h40);
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(bus.stall), 32'(0));
        chk("rst_mid_mtvec", bus.mtvec, RV);
        chk("rst_mid_mepc", bus.mepc, 32'h0);
        chk("rst_mid_mstatus", bus.csr_rdata, 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) drive_idle(1'b0);

        // Interrupt entry
        csr_wr(CSR_MTVEC, 32'h0000_0103);
        csr_wr(CSR_MSTATUS, 32'h8);
        do_instr(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 1, 1'b0);
        csr_rd(CSR_MSTATUS);
        csr_rd(CSR_MEPC);
        // Interrupt masked
        do_instr(1'b0, 1'b0, 1'b1, 32'h0000_0050, 1'b0, 32'h0, 2, 1'b0);
        // ecall with irq pending
        csr_wr(CSR_MSTATUS, 32'h8);
        do_instr(1'b1, 1'b0, 1'b1, 32'h0000_0060, 1'b0, 32'h0, 0, 1'b0);
        csr_rd(CSR_MCAUSE);
        // mret with irq pending, then the interrupt on the next boundary
        csr_wr(CSR_MEPC, 32'h0000_0044);
        csr_wr(CSR_MSTATUS, 32'h80);
        do_instr(1'b0, 1'b1, 1'b1, 32'h0000_0070, 1'b0, 32'h0, 0, 1'b0);
        csr_rd(CSR_MSTATUS);
        do_instr(1'b0, 1'b0, 1'b1, 32'h0000_0048, 1'b0, 32'h0, 0, 1'b0);
        // CSR write to mepc colliding with trap capture
        csr_wr(CSR_MSTATUS, 32'h8);
        do_instr(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_1234, 0, 1'b0);
        csr_rd(CSR_MEPC);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            do_instr(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 3) == 0), $urandom,
                     $urandom_range(0, 3), 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            quiet();
            cyc();
        end
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("rd_q_drained", 32'(rd_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
